// File: rtl/vga_text_ctrl_pkg.sv
// Shared constants and helpers for the VGA text-mode controller.
package vga_text_ctrl_pkg;

  // Character cell geometry and output channel width
  localparam int unsigned CELL_W      = 8;
  localparam int unsigned CELL_H      = 16;
  localparam int unsigned COLOR_WIDTH = 4;

  // Buffer payload widths: character code and {bg, fg} attribute
  localparam int unsigned CHAR_W = 8;
  localparam int unsigned ATTR_W = 6;

  // Default 640x480@60 timing
  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_H_FP       = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BP       = 48;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FP       = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 33;
  localparam int unsigned DEF_BLINK_LOG2 = 5;

  // Replicate one colour bit across a full output channel
  function automatic logic [COLOR_WIDTH-1:0] expand_bit(input logic b);
    return {COLOR_WIDTH{b}};
  endfunction

endpackage

// File: rtl/vga_text_ctrl_if.sv
// Host-side buffer write and cursor control bundle.
interface vga_text_ctrl_if
  import vga_text_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CHAR_W-1:0] wr_char;
  logic [ATTR_W-1:0] wr_color;
  logic              cur_en;
  logic [ADDR_W-1:0] cur_addr;

  modport master (
    output wr_en, wr_addr, wr_char, wr_color, cur_en, cur_addr
  );

  modport slave (
    input wr_en, wr_addr, wr_char, wr_color, cur_en, cur_addr
  );

endinterface

// File: rtl/vga_text_ctrl_font_rom.sv
// 256-glyph 8x16 font, synchronous read; bit 7 of each row is the leftmost pixel.
module vga_text_ctrl_font_rom
  import vga_text_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic [CHAR_W-1:0] i_char,
  input  logic [3:0]        i_row,
  output logic [7:0]        o_bits
);

  // Glyph table: a few real glyphs, a solid block, and a code-derived pattern
  // for every other character so any cell produces a predictable image.
  function automatic logic [7:0] glyph_row(input logic [CHAR_W-1:0] code,
                                           input logic [3:0]        row);
    logic [7:0] g;
    g = 8'h00;
    case (code)
      8'h00, 8'h20: g = 8'h00;
      8'h41: begin
        case (row)
          4'd2:                      g = 8'h10;
          4'd3:                      g = 8'h38;
          4'd4:                      g = 8'h6C;
          4'd5, 4'd6:                g = 8'hC6;
          4'd7:                      g = 8'hFE;
          4'd8, 4'd9, 4'd10, 4'd11:  g = 8'hC6;
          default:                   g = 8'h00;
        endcase
      end
      8'h42: begin
        case (row)
          4'd2, 4'd11:               g = 8'hFC;
          4'd3, 4'd4, 4'd5:          g = 8'h66;
          4'd6:                      g = 8'h7C;
          4'd7, 4'd8, 4'd9, 4'd10:   g = 8'h66;
          default:                   g = 8'h00;
        endcase
      end
      8'hDB: g = 8'hFF;
      default: g = ((row >= 4'd2) && (row <= 4'd13)) ? code : 8'h00;
    endcase
    return g;
  endfunction

  // Registered ROM read
  always_ff @(posedge clk) begin
    o_bits <= glyph_row(i_char, i_row);
  end

endmodule

// File: rtl/vga_text_ctrl.sv
// VGA text-mode controller: raster counters, character buffer, glyph lookup,
// blinking cursor and a 3-stage pipeline to aligned sync/RGB outputs.
module vga_text_ctrl
  import vga_text_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned BLINK_LOG2 = DEF_BLINK_LOG2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vga_text_ctrl_if.slave         host,
  output logic                   hsync,
  output logic                   vsync,
  output logic [COLOR_WIDTH-1:0] red,
  output logic [COLOR_WIDTH-1:0] green,
  output logic [COLOR_WIDTH-1:0] blue,
  output logic                   frame_start
);

  localparam int unsigned COLS     = H_ACTIVE / CELL_W;
  localparam int unsigned ROWS     = V_ACTIVE / CELL_H;
  localparam int unsigned CELLS    = COLS * ROWS;
  localparam int unsigned ADDR_W   = $clog2(CELLS);
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W     = $clog2(H_TOTAL);
  localparam int unsigned VC_W     = $clog2(V_TOTAL);
  localparam int unsigned FC_W     = BLINK_LOG2 + 1;
  localparam int unsigned ROW_W    = $clog2(CELL_H);
  localparam int unsigned COL_W    = $clog2(CELL_W);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned BUF_W    = CHAR_W + ATTR_W;

  // S0 state
  logic [HC_W-1:0] r_h_cnt;
  logic [VC_W-1:0] r_v_cnt;
  logic [FC_W-1:0] r_frame_cnt;

  // S0 decode
  logic              w_active;
  logic              w_hs_on;
  logic              w_vs_on;
  logic              w_first;
  logic [31:0]       w_cell;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ROW_W-1:0]  w_gly_row;
  logic [COL_W-1:0]  w_gly_col;
  logic              w_cur_hit;
  logic              w_wr_ok;

  // S1 state
  logic [BUF_W-1:0]  r_rd_data;
  logic              r1_active;
  logic              r1_hs;
  logic              r1_vs;
  logic              r1_first;
  logic [ROW_W-1:0]  r1_row;
  logic [COL_W-1:0]  r1_col;
  logic              r1_cur;
  logic [CHAR_W-1:0] w_rd_char;
  logic [ATTR_W-1:0] w_rd_color;

  // S2 state
  logic [7:0]        w_gly_bits;
  logic              r2_active;
  logic              r2_hs;
  logic              r2_vs;
  logic              r2_first;
  logic [COL_W-1:0]  r2_col;
  logic              r2_cur;
  logic [ATTR_W-1:0] r2_color;

  // S3 select
  logic              w_pix_on;
  logic [2:0]        w_rgb_sel;

  // Character buffer storage; intentionally not reset
  logic [BUF_W-1:0]  r_mem [CELLS];

  // Free-running raster and frame counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_cnt <= '0;
    end else if (r_h_cnt == HC_W'(H_TOTAL - 1)) begin
      r_h_cnt <= '0;
      if (r_v_cnt == VC_W'(V_TOTAL - 1)) begin
        r_v_cnt     <= '0;
        r_frame_cnt <= r_frame_cnt + FC_W'(1);
      end else begin
        r_v_cnt <= r_v_cnt + VC_W'(1);
      end
    end else begin
      r_h_cnt <= r_h_cnt + HC_W'(1);
    end
  end

  // Raster decode: active window, sync regions, cell address and cursor hit
  always_comb begin
    w_active  = (32'(r_h_cnt) < H_ACTIVE) && (32'(r_v_cnt) < V_ACTIVE);
    w_hs_on   = (32'(r_h_cnt) >= HS_START) && (32'(r_h_cnt) < HS_END);
    w_vs_on   = (32'(r_v_cnt) >= VS_START) && (32'(r_v_cnt) < VS_END);
    w_first   = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_cell    = (32'(r_v_cnt) / CELL_H) * COLS + (32'(r_h_cnt) / CELL_W);
    // Blanking addresses would run past the buffer; park the read on cell 0
    w_rd_addr = w_active ? ADDR_W'(w_cell) : '0;
    w_gly_row = r_v_cnt[ROW_W-1:0];
    w_gly_col = r_h_cnt[COL_W-1:0];
    w_cur_hit = host.cur_en && w_active
              && (w_cell == 32'(host.cur_addr))
              && (w_gly_row >= ROW_W'(CELL_H - 2))
              && r_frame_cnt[BLINK_LOG2];
    w_wr_ok   = host.wr_en && (32'(host.wr_addr) < CELLS);
  end

  // Buffer: host write port and scan read port, read-first on collision
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[ADDR_W'(host.wr_addr)] <= {host.wr_char, host.wr_color};
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  assign w_rd_char  = r_rd_data[BUF_W-1 -: CHAR_W];
  assign w_rd_color = r_rd_data[ATTR_W-1:0];

  // S1: carry raster control alongside the buffer read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_active <= 1'b0;
      r1_hs     <= 1'b0;
      r1_vs     <= 1'b0;
      r1_first  <= 1'b0;
      r1_row    <= '0;
      r1_col    <= '0;
      r1_cur    <= 1'b0;
    end else begin
      r1_active <= w_active;
      r1_hs     <= w_hs_on;
      r1_vs     <= w_vs_on;
      r1_first  <= w_first;
      r1_row    <= w_gly_row;
      r1_col    <= w_gly_col;
      r1_cur    <= w_cur_hit;
    end
  end

  vga_text_ctrl_font_rom u_font_rom (
    .clk    (clk),
    .i_char (w_rd_char),
    .i_row  (r1_row),
    .o_bits (w_gly_bits)
  );

  // S2: carry control and attribute alongside the glyph read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2_active <= 1'b0;
      r2_hs     <= 1'b0;
      r2_vs     <= 1'b0;
      r2_first  <= 1'b0;
      r2_col    <= '0;
      r2_cur    <= 1'b0;
      r2_color  <= '0;
    end else begin
      r2_active <= r1_active;
      r2_hs     <= r1_hs;
      r2_vs     <= r1_vs;
      r2_first  <= r1_first;
      r2_col    <= r1_col;
      r2_cur    <= r1_cur;
      r2_color  <= w_rd_color;
    end
  end

  // Pixel select: cursor forces foreground, otherwise glyph bit chooses fg/bg
  always_comb begin
    w_pix_on  = r2_cur | w_gly_bits[COL_W'(CELL_W - 1) - r2_col];
    w_rgb_sel = w_pix_on ? r2_color[2:0] : r2_color[5:3];
  end

  // S3: output register with blanking and sync polarity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= r2_hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= r2_vs ? SYNC_POL : ~SYNC_POL;
      red         <= r2_active ? expand_bit(w_rgb_sel[2]) : '0;
      green       <= r2_active ? expand_bit(w_rgb_sel[1]) : '0;
      blue        <= r2_active ? expand_bit(w_rgb_sel[0]) : '0;
      frame_start <= r2_first;
    end
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed bench for vga_text_ctrl on a reduced 40x32 raster (5x2 cells).
module tb_vga_text_ctrl;
  import vga_text_ctrl_pkg::*;

  localparam int H_TOT = 48;    // 40 + 2 + 4 + 2
  localparam int V_TOT = 36;    // 32 + 1 + 2 + 1
  localparam int FRAME = H_TOT * V_TOT;
  localparam int LIMIT = 4 * FRAME;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_text_ctrl_if #(.ADDR_W(4)) host_if ();

  logic                   hsync, vsync, frame_start;
  logic [COLOR_WIDTH-1:0] red, green, blue;
  logic [11:0]            rgb;
  assign rgb = {red, green, blue};

  vga_text_ctrl #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(32), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .BLINK_LOG2(0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (host_if),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_start (frame_start)
  );

  int checks = 0;
  int failures = 0;

  // Reference raster position, used only to know where the scan is
  int m_h = 0, m_v = 0, m_f = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_h <= 0; m_v <= 0; m_f <= 0;
    end else if (m_h == H_TOT - 1) begin
      m_h <= 0;
      if (m_v == V_TOT - 1) begin
        m_v <= 0;
        m_f <= m_f + 1;
      end else begin
        m_v <= m_v + 1;
      end
    end else begin
      m_h <= m_h + 1;
    end
  end

  // Expected pixel colour for glyph row bits at a column with a {bg,fg} attribute
  function automatic logic [11:0] px(input logic [7:0] bits, input int col, input logic [5:0] color);
    logic [2:0] c;
    c = bits[7 - col] ? color[2:0] : color[5:3];
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

  // Stop on the negedge where the scan counter is at (h,v); par selects frame parity (-1 any)
  task automatic wait_hv(input int h, input int v, input int par);
    int n;
    n = 0;
    @(negedge clk);
    while (!(m_h == h && m_v == v && (par < 0 || (m_f % 2) == par)) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      checks++; failures++;
      $display("FAIL wait_hv timeout h=%0d v=%0d got_pos=%0d,%0d required_pos=%0d,%0d", h, v, m_h, m_v, h, v);
    end
  endtask

  task automatic write_cell(input int a, input logic [7:0] ch, input logic [5:0] col);
    @(negedge clk);
    host_if.wr_en    = 1'b1;
    host_if.wr_addr  = 4'(a);
    host_if.wr_char  = ch;
    host_if.wr_color = col;
    @(negedge clk);
    host_if.wr_en    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rgb !== 12'h000)     begin failures++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
    checks++; if (hsync !== 1'b1)      begin failures++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
    checks++; if (vsync !== 1'b1)      begin failures++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (frame_start !== (k == 3)) begin
        failures++;
        $display("FAIL release_fs cycle=%0d got=%b exp=%b", k, frame_start, (k == 3));
      end
    end
  endtask

  task automatic test_sync_timing();
    int ones;
    // hsync across one line: low for pixels 42..45
    wait_hv(0, 0, -1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < H_TOT; k++) begin
      checks++;
      if (hsync !== !(k >= 42 && k < 46)) begin
        failures++;
        $display("FAIL hsync px=%0d got=%b exp=%b", k, hsync, !(k >= 42 && k < 46));
      end
      @(negedge clk);
    end
    // vsync per line: low on lines 33..34
    for (int v = 0; v < V_TOT; v++) begin
      wait_hv(0, v, -1);
      repeat (3) @(negedge clk);
      checks++;
      if (vsync !== !(v == 33 || v == 34)) begin
        failures++;
        $display("FAIL vsync line=%0d got=%b exp=%b", v, vsync, !(v == 33 || v == 34));
      end
    end
    // frame_start: exactly one pulse per 1728-cycle frame
    wait_hv(0, 0, -1);
    repeat (3) @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL fs_first got=%b exp=1", frame_start); end
    ones = 0;
    for (int k = 1; k < FRAME; k++) begin
      @(negedge clk);
      if (frame_start === 1'b1) ones++;
    end
    checks++; if (ones != 0) begin failures++; $display("FAIL fs_extra got=%0d exp=0", ones); end
    @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL fs_period got=%b exp=1", frame_start); end
  endtask

  task automatic test_glyph();
    int         tv [7];
    int         th [7];
    logic [7:0] tbits [7];
    logic [5:0] tcol [7];
    logic [11:0] e;
    write_cell(0, 8'h41, 6'b000_111);
    write_cell(1, 8'h42, 6'b001_100);
    write_cell(2, 8'h5A, 6'b110_011);
    write_cell(4, 8'hDB, 6'b000_111);
    tv    = '{0, 0, 2, 2, 7, 5, 5};
    th    = '{0, 8, 0, 8, 0, 16, 32};
    tbits = '{8'h00, 8'h00, 8'h10, 8'hFC, 8'hFE, 8'h5A, 8'hFF};
    tcol  = '{6'b000_111, 6'b001_100, 6'b000_111, 6'b001_100, 6'b000_111, 6'b110_011, 6'b000_111};
    for (int t = 0; t < 7; t++) begin
      wait_hv(th[t], tv[t], -1);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        e = px(tbits[t], k, tcol[t]);
        checks++;
        if (rgb !== e) begin
          failures++;
          $display("FAIL glyph line=%0d px=%0d got=%h exp=%h", tv[t], th[t] + k, rgb, e);
        end
        @(negedge clk);
      end
    end
    // Right-edge blanking: last active pixel white, porch black
    wait_hv(39, 5, -1);
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'hFFF) begin failures++; $display("FAIL edge_px39 got=%h exp=fff", rgb); end
    for (int k = 40; k < H_TOT; k++) begin
      @(negedge clk);
      checks++;
      if (rgb !== 12'h000) begin failures++; $display("FAIL hblank px=%0d got=%h exp=000", k, rgb); end
    end
    // Vertical blanking line
    wait_hv(32, 32, -1);
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL vblank got=%h exp=000", rgb); end
  endtask

  task automatic test_bad_addr();
    write_cell(12, 8'h42, 6'b111_111);
    write_cell(15, 8'hDB, 6'b101_010);
    wait_hv(0, 2, -1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rgb !== px(8'h10, k, 6'b000_111)) begin
        failures++;
        $display("FAIL bad_addr_cell0 px=%0d got=%h exp=%h", k, rgb, px(8'h10, k, 6'b000_111));
      end
      @(negedge clk);
    end
    wait_hv(16, 5, -1);
    repeat (3) @(negedge clk);
    checks++;
    if (rgb !== px(8'h5A, 0, 6'b110_011)) begin
      failures++;
      $display("FAIL bad_addr_cell2 got=%h exp=%h", rgb, px(8'h5A, 0, 6'b110_011));
    end
  endtask

  task automatic test_collision();
    write_cell(5, 8'hDB, 6'b000_111);
    wait_hv(3, 20, -1);
    host_if.wr_en    = 1'b1;
    host_if.wr_addr  = 4'd5;
    host_if.wr_char  = 8'h00;
    host_if.wr_color = 6'b000_111;
    @(negedge clk);
    host_if.wr_en    = 1'b0;
    @(negedge clk);
    checks++; if (rgb !== 12'hFFF) begin failures++; $display("FAIL coll_px2 got=%h exp=fff", rgb); end
    @(negedge clk);
    checks++; if (rgb !== 12'hFFF) begin failures++; $display("FAIL coll_px3_old got=%h exp=fff", rgb); end
    @(negedge clk);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL coll_px4_new got=%h exp=000", rgb); end
    wait_hv(3, 21, -1);
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL coll_next_line got=%h exp=000", rgb); end
  endtask

  task automatic test_cursor();
    write_cell(6, 8'h00, 6'b000_000);
    write_cell(7, 8'h00, 6'b010_001);
    host_if.cur_addr = 4'd7;
    host_if.cur_en   = 1'b1;
    // Odd frame, glyph row 13: no cursor
    wait_hv(16, 29, 1);
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'h0F0) begin failures++; $display("FAIL cur_row13 got=%h exp=0f0", rgb); end
    // Odd frame, row 14: neighbour cell unaffected, cursor cell solid fg
    wait_hv(15, 30, 1);
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL cur_neighbour got=%h exp=000", rgb); end
    for (int k = 16; k < 24; k++) begin
      @(negedge clk);
      checks++;
      if (rgb !== 12'h00F) begin failures++; $display("FAIL cur_on px=%0d got=%h exp=00f", k, rgb); end
    end
    @(negedge clk);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL cur_after got=%h exp=000", rgb); end
    wait_hv(23, 31, 1);
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'h00F) begin failures++; $display("FAIL cur_row15 got=%h exp=00f", rgb); end
    // Even frame: normal glyph (blank -> bg)
    wait_hv(16, 30, 0);
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'h0F0) begin failures++; $display("FAIL cur_even got=%h exp=0f0", rgb); end
    // Disabled on an odd frame
    host_if.cur_en = 1'b0;
    wait_hv(16, 30, 1);
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'h0F0) begin failures++; $display("FAIL cur_disabled got=%h exp=0f0", rgb); end
  endtask

  task automatic test_midframe_reset();
    write_cell(8, 8'hDB, 6'b000_111);
    wait_hv(30, 20, -1);
    checks++; if (rgb !== 12'hFFF) begin failures++; $display("FAIL mid_pre got=%h exp=fff", rgb); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (rgb !== 12'h000)      begin failures++; $display("FAIL mid_rgb got=%h exp=000", rgb); end
    checks++; if (hsync !== 1'b1)       begin failures++; $display("FAIL mid_hsync got=%b exp=1", hsync); end
    checks++; if (vsync !== 1'b1)       begin failures++; $display("FAIL mid_vsync got=%b exp=1", vsync); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL mid_fs got=%b exp=0", frame_start); end
    repeat (4) @(negedge clk);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL mid_hold_rgb got=%h exp=000", rgb); end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (frame_start !== (k == 3)) begin
        failures++;
        $display("FAIL mid_release_fs cycle=%0d got=%b exp=%b", k, frame_start, (k == 3));
      end
    end
  endtask

  initial begin
    host_if.wr_en    = 1'b0;
    host_if.wr_addr  = '0;
    host_if.wr_char  = '0;
    host_if.wr_color = '0;
    host_if.cur_en   = 1'b0;
    host_if.cur_addr = '0;
    test_reset();
    for (int i = 0; i < 10; i++) write_cell(i, 8'h00, 6'b000_000);
    test_sync_timing();
    test_glyph();
    test_bad_addr();
    test_collision();
    test_cursor();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
